regfile_access_ctrl: RTL

- Initiator-side controller for the 2-read/1-write register file; it drives the read addresses, write address, write data and write enable of that file.
- Accepts one operation at a time over a valid/ready request handshake.
- Sequence per operation: issue both reads, capture the operands, compute a 16-bit result, issue one write-back, report completion.
- Sits between the instruction-issue logic and the register file in the lab datapath.

---
 rtl/regfile_access_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for a 2R/1W register file: read, execute, write back.
// Fixed 4-cycle occupancy per operation; reqReady is low while an operation is in flight.
module regfile_access_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              reqValid_i,
  output logic              reqReady_o,
  input  logic [1:0]        reqOp_i,
  input  logic [ADDR_W-1:0] reqRs1_i,
  input  logic [ADDR_W-1:0] reqRs2_i,
  input  logic [ADDR_W-1:0] reqRd_i,
  input  logic [DATA_W-1:0] reqImm_i,
  output logic [ADDR_W-1:0] read1_o,
  output logic [ADDR_W-1:0] read2_o,
  input  logic [DATA_W-1:0] dataRead1_i,
  input  logic [DATA_W-1:0] dataRead2_i,
  output logic [ADDR_W-1:0] write_o,
  output logic [DATA_W-1:0] dataToWrite_o,
  output logic              writeEn_o,
  output logic              doneValid_o,
  output logic [DATA_W-1:0] doneData_o,
  output logic              carry_o,
  output logic [15:0]       opCount_o
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [ADDR_W-1:0]   read1_q, read1_d;
  logic [ADDR_W-1:0]   read2_q, read2_d;
  logic [ADDR_W-1:0]   write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   done_data_q, done_data_d;
  logic                carry_q, carry_d;
  logic [15:0]         op_count_q, op_count_d;
  logic [DATA_W:0]     exec_sum;
  logic [DATA_W-1:0]   exec_res;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      read1_q     <= '0;
      read2_q     <= '0;
      write_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      carry_q     <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      read1_q     <= read1_d;
      read2_q     <= read2_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      carry_q     <= carry_d;
      op_count_q  <= op_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    op_d        = op_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    read1_d     = read1_q;
    read2_d     = read2_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
    done_d      = 1'b0;
    done_data_d = done_data_q;
    carry_d     = carry_q;
    op_count_d  = op_count_q;
    exec_sum    = '0;
    exec_res    = '0;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        // ready_q, not ready_d: the first cycle out of reset must not accept
        if (reqValid_i && ready_q) begin
          op_d    = reqOp_i;
          rd_d    = reqRd_i;
          imm_d   = reqImm_i;
          read1_d = reqRs1_i;
          read2_d = reqRs2_i;
          ready_d = 1'b0;
          state_d = READ;
        end
      end
      READ: begin
        opa_d   = dataRead1_i;
        opb_d   = dataRead2_i;
        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            exec_sum = {1'b0, opa_q} + {1'b0, opb_q};
            exec_res = exec_sum[DATA_W-1:0];
            carry_d  = exec_sum[DATA_W];
          end
          OP_SUB: begin
            exec_res = opa_q - opb_q;
            carry_d  = (opa_q < opb_q);
          end
          OP_AND:  exec_res = opa_q & opb_q;
          default: exec_res = imm_q;
        endcase
        write_d     = rd_q;
        wdata_d     = exec_res;
        done_data_d = exec_res;
        we_d        = 1'b1;
        done_d      = 1'b1;
        state_d     = WB;
      end
      WB: begin
        op_count_d = op_count_q + 16'd1;
        ready_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign reqReady_o    = ready_q;
  assign read1_o       = read1_q;
  assign read2_o       = read2_q;
  assign write_o       = write_q;
  assign dataToWrite_o = wdata_q;
  assign writeEn_o     = we_q;
  assign doneValid_o   = done_q;
  assign doneData_o    = done_data_q;
  assign carry_o       = carry_q;
  assign opCount_o     = op_count_q;

endmodule
